// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_arbiter
// Brief   : Round-robin share of single-port data memory between core and DMA.
// Revision: 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              grant_id
);

    localparam logic [3:0] c_mem_latency = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_last_grant;
    logic                r_port;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_count;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_grant_sel;
    logic                w_accept;
    logic                w_capture;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        w_grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_sel = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_sel = 1'b1;
        end
    end

    // Ready is qualified by reset so nothing is offered while held in reset.
    assign req0_ready = reset && (r_state == S_IDLE) && req0_valid && !w_grant_sel;
    assign req1_ready = reset && (r_state == S_IDLE) && req1_valid &&  w_grant_sel;
    assign w_accept   = req0_ready || req1_ready;

    assign w_capture = ((r_state == S_ACCESS) && (c_mem_latency == 4'd0)) ||
                       ((r_state == S_WAIT)   && (r_count == 4'd1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = (c_mem_latency == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT:   if (r_count == 4'd1) w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_count      <= 4'd0;
            r_rdata      <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_sel;
                r_port       <= w_grant_sel;
                r_write      <= w_grant_sel ? req1_write : req0_write;
                r_addr       <= w_grant_sel ? req1_addr  : req0_addr;
                r_wdata      <= w_grant_sel ? req1_wdata : req0_wdata;
            end
            if (r_state == S_ACCESS) begin
                r_count <= c_mem_latency;
            end else if (r_state == S_WAIT) begin
                r_count <= r_count - 4'd1;
            end
            if (w_capture) begin
                r_rdata <= r_write ? '0 : mem_read_data;
            end
        end
    end

    assign mem_read_enable  = (r_state == S_ACCESS) && !r_write;
    assign mem_write_enable = (r_state == S_ACCESS) &&  r_write;
    assign mem_address      = r_addr;
    assign mem_write_data   = r_wdata;
    assign rsp0_valid       = (r_state == S_RESP) && !r_port;
    assign rsp1_valid       = (r_state == S_RESP) &&  r_port;
    assign rsp_rdata        = r_rdata;
    assign busy             = (r_state != S_IDLE);
    assign grant_id         = r_port;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_memory_arbiter
// Brief   : Directed bench for data_memory_arbiter at latencies 1, 0 and 3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    // latency-1 instance, both ports exercised
    logic        req0_valid, req0_ready, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_rdata;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, grant_id;

    // latency-0 instance (z_) and latency-3 instance (t_), core port only
    logic        z_valid, z_ready, z_ready1, z_rsp, z_rsp1, z_re, z_we, z_busy, z_gid;
    logic [31:0] z_addr_in, z_rdata, z_addr, z_wdata, z_mrdata;
    logic        t_valid, t_ready, t_ready1, t_rsp, t_rsp1, t_re, t_we, t_busy, t_gid;
    logic [31:0] t_addr_in, t_rdata, t_addr, t_wdata, t_mrdata;

    data_memory_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(1)) u1 (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
        .mem_read_enable(mem_re), .mem_write_enable(mem_we), .mem_address(mem_addr),
        .mem_write_data(mem_wdata), .mem_read_data(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    data_memory_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(0)) u0 (
        .clock(clock), .reset(reset),
        .req0_valid(z_valid), .req0_ready(z_ready), .req0_write(1'b0),
        .req0_addr(z_addr_in), .req0_wdata(32'h0),
        .req1_valid(1'b0), .req1_ready(z_ready1), .req1_write(1'b0),
        .req1_addr(32'h0), .req1_wdata(32'h0),
        .rsp0_valid(z_rsp), .rsp1_valid(z_rsp1), .rsp_rdata(z_rdata),
        .mem_read_enable(z_re), .mem_write_enable(z_we), .mem_address(z_addr),
        .mem_write_data(z_wdata), .mem_read_data(z_mrdata),
        .busy(z_busy), .grant_id(z_gid)
    );

    data_memory_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(3)) u3 (
        .clock(clock), .reset(reset),
        .req0_valid(t_valid), .req0_ready(t_ready), .req0_write(1'b0),
        .req0_addr(t_addr_in), .req0_wdata(32'h0),
        .req1_valid(1'b0), .req1_ready(t_ready1), .req1_write(1'b0),
        .req1_addr(32'h0), .req1_wdata(32'h0),
        .rsp0_valid(t_rsp), .rsp1_valid(t_rsp1), .rsp_rdata(t_rdata),
        .mem_read_enable(t_re), .mem_write_enable(t_we), .mem_address(t_addr),
        .mem_write_data(t_wdata), .mem_read_data(t_mrdata),
        .busy(t_busy), .grant_id(t_gid)
    );

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        if (a == 32'h14) return 32'h55556666;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory models: data appears exactly LATENCY cycles after the enable, garbage otherwise.
    int          m1_cnt, m3_cnt;
    logic [31:0] m1_addr, m3_addr;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m1_cnt <= 0; m1_addr <= 0; m3_cnt <= 0; m3_addr <= 0;
        end else begin
            if (mem_re) begin m1_cnt <= 1; m1_addr <= mem_addr; end
            else if (m1_cnt != 0) m1_cnt <= m1_cnt + 1;
            if (t_re) begin m3_cnt <= 1; m3_addr <= t_addr; end
            else if (m3_cnt != 0) m3_cnt <= m3_cnt + 1;
        end
    end
    assign mem_rdata = (m1_cnt == 1) ? rd_fn(m1_addr) : 32'hBAD0BAD0;
    assign t_mrdata  = (m3_cnt == 3) ? rd_fn(m3_addr) : 32'hBAD0BAD0;
    assign z_mrdata  = z_re ? rd_fn(z_addr) : 32'hBAD0BAD0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; z_valid = 1'b1; t_valid = 1'b1;
        req0_addr = 32'h10; req1_addr = 32'h14;
        step(); step(); step(); #1;
        total++; if ({req0_ready, req1_ready, z_ready, t_ready} !== 4'b0) begin
            bad++; $display("FAIL reset_ready got=%b want=0000", {req0_ready, req1_ready, z_ready, t_ready}); end
        total++; if ({busy, mem_re, mem_we, rsp0_valid, rsp1_valid, grant_id} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000", {busy, mem_re, mem_we, rsp0_valid, rsp1_valid, grant_id}); end
        total++; if ({mem_addr, mem_wdata, rsp_rdata} !== 96'h0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, rsp_rdata}); end
        req0_valid = 1'b0; req1_valid = 1'b0; z_valid = 1'b0; t_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_core_load();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h10; #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL load_accept got=%b want=10", {req0_ready, req1_ready}); end
        step(); req0_valid = 1'b0; #1;
        total++; if ({mem_re, mem_we, busy, grant_id} !== 4'b1010 || mem_addr !== 32'h10) begin
            bad++; $display("FAIL load_enable got=%b/%h want=1010/00000010", {mem_re, mem_we, busy, grant_id}, mem_addr); end
        step(); #1;
        total++; if ({mem_re, rsp0_valid, mem_addr} !== {2'b00, 32'h10}) begin
            bad++; $display("FAIL load_wait got=%b/%h want=00/00000010", {mem_re, rsp0_valid}, mem_addr); end
        step(); #1;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL load_rsp got=%b/%h want=10/deadbeef", {rsp0_valid, rsp1_valid}, rsp_rdata); end
        step(); #1;
        total++; if ({rsp0_valid, busy} !== 2'b00 || rsp_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL load_after got=%b/%h want=00/deadbeef", {rsp0_valid, busy}, rsp_rdata); end
    endtask

    task automatic test_alternation();
        int g[$];
        int n0 = 0;
        int n1 = 0;
        int exp_g[4] = '{0, 1, 0, 1};
        reset = 1'b0; step(); reset = 1'b1; step();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h14;
        for (int k = 0; k < 40 && g.size() < 4; k++) begin
            #1;
            if (req0_ready && req1_ready) begin
                total++; bad++; $display("FAIL both_ready got=11 want=not both");
            end
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
            if (rsp0_valid) n0++;
            if (rsp1_valid) n1++;
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (rsp0_valid) n0++;
            if (rsp1_valid) begin
                n1++;
                total++; if (rsp_rdata !== 32'h55556666) begin
                    bad++; $display("FAIL alt_rsp1_data got=%h want=55556666", rsp_rdata); end
            end
            step();
        end
        total++; if (g.size() != 4) begin
            bad++; $display("FAIL alt_grants got=%0d want=4", g.size()); end
        for (int i = 0; i < 4 && i < g.size(); i++) begin
            total++; if (g[i] != exp_g[i]) begin
                bad++; $display("FAIL alt_order[%0d] got=%0d want=%0d", i, g[i], exp_g[i]); end
        end
        total++; if (n0 != 2 || n1 != 2) begin
            bad++; $display("FAIL alt_rsp_count got=%0d,%0d want=2,2", n0, n1); end
    endtask

    task automatic test_store_vs_core();
        bit seen = 1'b0;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h1234; #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL st_accept got=%b want=01", {req0_ready, req1_ready}); end
        step();
        req1_valid = 1'b0; req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h10; #1;
        total++; if ({mem_we, mem_re, req0_ready, grant_id} !== 4'b1001 ||
                     mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin
            bad++; $display("FAIL st_write got=%b/%h/%h want=1001/00000020/00001234",
                            {mem_we, mem_re, req0_ready, grant_id}, mem_addr, mem_wdata); end
        step(); #1;
        total++; if ({mem_we, req0_ready} !== 2'b00) begin
            bad++; $display("FAIL st_one_cycle got=%b want=00", {mem_we, req0_ready}); end
        step(); #1;
        total++; if ({rsp1_valid, rsp0_valid, req0_ready} !== 3'b100 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL st_rsp got=%b/%h want=100/00000000", {rsp1_valid, rsp0_valid, req0_ready}, rsp_rdata); end
        step(); #1;
        total++; if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL st_core_after got=%b want=1", req0_ready); end
        step(); req0_valid = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (rsp0_valid) begin
                seen = 1'b1;
                total++; if (rsp_rdata !== 32'hDEADBEEF) begin
                    bad++; $display("FAIL st_core_data got=%h want=deadbeef", rsp_rdata); end
            end
            step();
        end
        total++; if (!seen) begin
            bad++; $display("FAIL st_core_rsp got=none want=pulse"); end
    endtask

    task automatic test_latency0();
        z_valid = 1'b1; z_addr_in = 32'h40; #1;
        total++; if (z_ready !== 1'b1) begin
            bad++; $display("FAIL lat0_accept got=%b want=1", z_ready); end
        for (int k = 1; k <= 6; k++) begin
            step(); if (k == 1) z_valid = 1'b0; #1;
            total++; if (z_rsp !== (k == 2)) begin
                bad++; $display("FAIL lat0_rsp@T+%0d got=%b want=%b", k, z_rsp, (k == 2)); end
            if (k == 2) begin
                total++; if (z_rdata !== 32'h0040C0DE) begin
                    bad++; $display("FAIL lat0_data got=%h want=0040c0de", z_rdata); end
            end
        end
    endtask

    task automatic test_latency3(input logic [31:0] addr, input logic [31:0] want);
        t_valid = 1'b1; t_addr_in = addr; #1;
        total++; if (t_ready !== 1'b1) begin
            bad++; $display("FAIL lat3_accept got=%b want=1", t_ready); end
        for (int k = 1; k <= 7; k++) begin
            step(); if (k == 1) t_valid = 1'b0; #1;
            total++; if (t_rsp !== (k == 5)) begin
                bad++; $display("FAIL lat3_rsp@T+%0d got=%b want=%b", k, t_rsp, (k == 5)); end
            if (k == 5) begin
                total++; if (t_rdata !== want) begin
                    bad++; $display("FAIL lat3_data got=%h want=%h", t_rdata, want); end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        t_valid = 1'b1; t_addr_in = 32'h48;
        step(); t_valid = 1'b0; #1;
        total++; if (t_re !== 1'b1) begin
            bad++; $display("FAIL rw_enable got=%b want=1", t_re); end
        step(); #1;
        reset = 1'b0; #1;
        total++; if ({t_busy, t_re, t_we, t_rsp} !== 4'b0) begin
            bad++; $display("FAIL rw_drop got=%b want=0000", {t_busy, t_re, t_we, t_rsp}); end
        for (int k = 0; k < 5; k++) begin
            step();
            total++; if ({t_rsp, t_busy} !== 2'b00) begin
                bad++; $display("FAIL rw_hold got=%b want=00", {t_rsp, t_busy}); end
        end
        reset = 1'b1;
        step();
        test_latency3(32'h4C, 32'h004CC0DE);
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 32'h0; req0_wdata = 32'h0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 32'h0; req1_wdata = 32'h0;
        z_valid = 1'b0; z_addr_in = 32'h0; t_valid = 1'b0; t_addr_in = 32'h0;
        test_reset();
        test_core_load();
        test_alternation();
        test_store_vs_core();
        test_latency0();
        test_latency3(32'h44, 32'h0044C0DE);
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
